// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU load/store unit for a word-wide data memory, with alignment and access faults.
// Byte/half accesses need MEM_ACCESS_SUBWORD_EN; without it they fault as misaligned.
module mem_access_unit #(
    parameter logic [31:0] FAULT_RDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_accessable
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t state, state_nxt;
    logic l_we, l_sext, fault_q, misaligned;
    logic [1:0] l_size;
    logic [31:0] l_addr, wbuf, load_val, merged;
`ifdef MEM_ACCESS_SUBWORD_EN
    logic [7:0] lane_b;
    logic [15:0] lane_h;
    assign misaligned = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    assign lane_b = mem_rdata[{l_addr[1:0], 3'b000} +: 8];
    assign lane_h = mem_rdata[{l_addr[1], 4'b0000} +: 16];
    assign load_val = (l_size == 2'b00) ? {{24{l_sext & lane_b[7]}}, lane_b} :
                      (l_size == 2'b01) ? {{16{l_sext & lane_h[15]}}, lane_h} : mem_rdata;
    // wbuf still holds the raw store data while in READ, so it supplies the new lane
    always_comb begin
        merged = mem_rdata;
        if (l_size == 2'b00)
            merged[{l_addr[1:0], 3'b000} +: 8] = wbuf[7:0];
        else if (l_size == 2'b01)
            merged[{l_addr[1], 4'b0000} +: 16] = wbuf[15:0];
    end
`else
    logic unused;
    assign misaligned = (size != 2'b10) || (addr[1:0] != 2'b00);
    assign load_val = mem_rdata;
    assign merged = mem_rdata;
    assign unused = ^{l_sext, l_size, l_addr[1:0]};
`endif

    assign ready = (state == IDLE);
    assign done = (state == DONE);
    assign fault = done && fault_q;
    assign mem_rd = (state == READ);
    assign mem_wr = (state == WRITE);
    assign mem_addr = (mem_rd || mem_wr) ? {l_addr[31:2], 2'b00} : 32'h0;
    assign mem_wdata = mem_wr ? wbuf : 32'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = misaligned ? DONE : (we && size == 2'b10) ? WRITE : READ;
            READ:    state_nxt = (!mem_accessable || !l_we) ? DONE : WRITE;
            WRITE:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_we <= 1'b0;
            l_sext <= 1'b0;
            l_size <= 2'b00;
            l_addr <= 32'h0;
            wbuf <= 32'h0;
            rdata <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                l_we <= we;
                l_sext <= sign_ext;
                l_size <= size;
                l_addr <= addr;
                wbuf <= wdata;
                fault_q <= misaligned;
                if (misaligned && !we)
                    rdata <= FAULT_RDATA;
            end
            if (state == READ) begin
                fault_q <= !mem_accessable;
                if (!l_we)
                    rdata <= mem_accessable ? load_val : FAULT_RDATA;
                else
                    wbuf <= merged;
            end
            if (state == WRITE)
                fault_q <= !mem_accessable;
        end
    end
endmodule
